// File: rtl/spi_flash_reader_pkg.sv
// Shared types and constants for the SPI flash read engine.
package spi_flash_reader_pkg;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_CMD,
      ST_ADDR,
      ST_DUMMY,
      ST_DATA,
      ST_GAP
   } state_t;

   localparam logic [7:0] CMD_READ      = 8'h03;
   localparam logic [7:0] CMD_FAST_READ = 8'h0B;

   localparam int unsigned CMD_BITS   = 8;
   localparam int unsigned ADDR_BITS  = 24;
   localparam int unsigned DUMMY_BITS = 8;
   localparam int unsigned DATA_BITS  = 32;

   // Flash returns bytes MSB-first in arrival order; the response word is little-endian.
   function automatic logic [31:0] bytes_le(input logic [31:0] w);
      return {w[7:0], w[15:8], w[23:16], w[31:24]};
   endfunction

endpackage

// File: rtl/spi_flash_reader_sck.sv
// SCK divider: CLK_DIV system clocks per half-period, with first-high and last-high strobes.
module spi_sck_gen #(
   parameter int unsigned CLK_DIV = 2
) (
   input  logic clk,
   input  logic rst,
   input  logic en,
   output logic sck,
   output logic rise,
   output logic fall
);

   logic [7:0] cnt;
   logic       last;

   assign last = (cnt == 8'(CLK_DIV - 1));

   always_ff @(posedge clk) begin
      if (rst || !en) begin
         cnt <= '0;
         sck <= 1'b0;
      end else if (last) begin
         cnt <= '0;
         sck <= ~sck;
      end else begin
         cnt <= cnt + 8'd1;
      end
   end

   // rise marks the first high cycle (sample point), fall the last high cycle (end of bit)
   assign rise = en && sck && (cnt == '0);
   assign fall = en && sck && last;

endmodule

// File: rtl/spi_flash_reader.sv
// Single-word SPI flash reader (mode 0). Define SPI_FLASH_FAST_READ_EN for 0x0B fast read with 8 dummy clocks.
module spi_flash_reader
   import spi_flash_reader_pkg::*;
#(
   parameter int unsigned CLK_DIV = 2
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        req_valid,
   output logic        req_ready,
   input  logic [23:0] req_addr,
   output logic        resp_valid,
   output logic [31:0] resp_data,
   output logic        spi_csb,
   output logic        spi_sck,
   output logic        spi_mosi,
   input  logic        spi_miso
);

`ifdef SPI_FLASH_FAST_READ_EN
   localparam logic [7:0] CMD = CMD_FAST_READ;
`else
   localparam logic [7:0] CMD = CMD_READ;
`endif

   state_t      state, state_n;
   logic [7:0]  bit_cnt, bit_cnt_n;
   logic [31:0] tx, tx_n;
   logic [31:0] rx, rx_n;
   logic [31:0] resp_data_n;
   logic        resp_valid_n;
   logic        shifting, sck_rise, sck_fall;

   assign shifting  = (state == ST_CMD) || (state == ST_ADDR) ||
                      (state == ST_DUMMY) || (state == ST_DATA);
   assign req_ready = (state == ST_IDLE);
   assign spi_csb   = !shifting;
   assign spi_mosi  = ((state == ST_CMD) || (state == ST_ADDR)) ? tx[31] : 1'b0;

   spi_sck_gen #(.CLK_DIV(CLK_DIV)) u_sck (
      .clk  (clk),
      .rst  (rst),
      .en   (shifting),
      .sck  (spi_sck),
      .rise (sck_rise),
      .fall (sck_fall)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         state      <= ST_IDLE;
         bit_cnt    <= '0;
         tx         <= '0;
         rx         <= '0;
         resp_data  <= '0;
         resp_valid <= 1'b0;
      end else begin
         state      <= state_n;
         bit_cnt    <= bit_cnt_n;
         tx         <= tx_n;
         rx         <= rx_n;
         resp_data  <= resp_data_n;
         resp_valid <= resp_valid_n;
      end
   end

   always_comb begin
      state_n      = state;
      bit_cnt_n    = bit_cnt;
      tx_n         = tx;
      rx_n         = rx;
      resp_data_n  = resp_data;
      resp_valid_n = 1'b0;

      if (state == ST_DATA && sck_rise)
         rx_n = {rx[30:0], spi_miso};
      if (shifting && sck_fall) begin
         tx_n      = {tx[30:0], 1'b0};
         bit_cnt_n = bit_cnt + 8'd1;
      end

      case (state)
         ST_IDLE: begin
            if (req_valid) begin
               state_n   = ST_CMD;
               tx_n      = {CMD, req_addr};
               bit_cnt_n = '0;
            end
         end
         ST_CMD: begin
            if (sck_fall && bit_cnt == 8'(CMD_BITS - 1)) begin
               state_n   = ST_ADDR;
               bit_cnt_n = '0;
            end
         end
         ST_ADDR: begin
            if (sck_fall && bit_cnt == 8'(ADDR_BITS - 1)) begin
`ifdef SPI_FLASH_FAST_READ_EN
               state_n   = ST_DUMMY;
`else
               state_n   = ST_DATA;
`endif
               bit_cnt_n = '0;
            end
         end
`ifdef SPI_FLASH_FAST_READ_EN
         ST_DUMMY: begin
            if (sck_fall && bit_cnt == 8'(DUMMY_BITS - 1)) begin
               state_n   = ST_DATA;
               bit_cnt_n = '0;
            end
         end
`endif
         ST_DATA: begin
            // with CLK_DIV=1 the last sample and the end of bit share a cycle, hence rx_n
            if (sck_fall && bit_cnt == 8'(DATA_BITS - 1)) begin
               state_n      = ST_GAP;
               bit_cnt_n    = '0;
               resp_valid_n = 1'b1;
               resp_data_n  = bytes_le(rx_n);
            end
         end
         ST_GAP: begin
            if (bit_cnt == 8'(CLK_DIV - 1)) begin
               state_n   = ST_IDLE;
               bit_cnt_n = '0;
            end else begin
               bit_cnt_n = bit_cnt + 8'd1;
            end
         end
         default: begin
            state_n   = ST_IDLE;
            bit_cnt_n = '0;
         end
      endcase
   end

endmodule

// File: doc/spi_flash_reader.md
SPI_FLASH_READER -- requirements
Module: spi_flash_reader

Interface
REQ-001 Parameter CLK_DIV, default 2, system clocks per SCK half-period; legal range 1..255.
REQ-002 clk  input  1  system clock; all logic on rising edge.
REQ-003 rst  input  1  reset, synchronous, active-high.
REQ-004 req_valid  input  1  read request present.
REQ-005 req_ready  output  1  block idle and able to accept a request.
REQ-006 req_addr  input  24  flash byte address.
REQ-007 resp_valid  output  1  one-cycle pulse, resp_data valid.
REQ-008 resp_data  output  32  read word, little-endian (first flash byte in bits 7:0).
REQ-009 spi_csb  output  1  flash chip select, active-low.
REQ-010 spi_sck  output  1  SPI clock, mode 0 (idles low).
REQ-011 spi_mosi  output  1  data to flash (IO0).
REQ-012 spi_miso  input  1  data from flash (IO1).

Function
REQ-013 Request accepted in a cycle where req_valid and req_ready are both high; req_addr captured that cycle.
REQ-014 States: IDLE, CMD (8 bits), ADDR (24 bits), DUMMY (8 bits, REQ-029 only), DATA (32 bits), GAP.
REQ-015 req_ready high only in IDLE.
REQ-016 Acceptance: next cycle csb low, sck low, mosi = command bit 7, state CMD.
REQ-017 Each bit: sck low CLK_DIV cycles, then high CLK_DIV cycles; mosi changes only while sck low (at start of bit); miso sampled in the cycle sck goes high.
REQ-018 All shifting MSB first; command byte 0x03, then address bits 23..0.
REQ-019 DATA: 4 bytes, each MSB first; byte n (n=0..3) placed in resp_data[8n+7:8n].
REQ-020 mosi driven 0 during DUMMY and DATA and while csb high.
REQ-021 After last DATA bit high phase: csb high, sck low, resp_valid pulses for one cycle, state GAP.
REQ-022 resp_valid asserts exactly 128*CLK_DIV+1 cycles after the acceptance cycle (no fast read).
REQ-023 GAP holds csb high CLK_DIV cycles, then IDLE; req_ready rises the cycle after GAP ends.
REQ-024 resp_data holds its value until the next resp_valid; not cleared in between.
REQ-025 req_valid while not ready is ignored; no queueing; req_addr changes after acceptance have no effect.
REQ-026 Bit and divider counters wrap only at their terminal counts; no partial transfers except by reset.

Reset
REQ-027 rst in any state, including mid-transfer: next cycle state IDLE, csb=1, sck=0, mosi=0, resp_valid=0, req_ready=1, resp_data=0, all counters 0; no resp_valid for the aborted transfer.
REQ-028 rst has priority over a simultaneous request.

Configuration
REQ-029 SPI_FLASH_FAST_READ_EN defined: command 0x0B, DUMMY state of 8 sck cycles between ADDR and DATA, resp_valid at 144*CLK_DIV+1 cycles after acceptance.
REQ-030 SPI_FLASH_FAST_READ_EN undefined: command 0x03, DUMMY state unreachable and not synthesised.

Structure
REQ-031 Shared package holds: state enumeration, command constants (0x03, 0x0B), bit-count constants (8, 24, 8, 32).
REQ-032 One sub-module, spi_sck_gen: divider counter producing sck plus one-cycle rise/fall strobes; FSM and shift registers stay in spi_flash_reader.

Verification
REQ-033 CLK_DIV=2, flash model preloaded 0x100..0x103 = 11 22 33 44; request 0x000100 -> mosi stream 0x03,0x000100; resp_data=0x44332211; resp_valid at cycle 257.
REQ-034 CLK_DIV=1, back-to-back requests 0x000000, 0x000004 with req_valid held -> two responses; csb high >=1 cycle between; second accepted only after req_ready returns.
REQ-035 rst asserted mid-ADDR -> next cycle csb=1, sck=0, req_ready=1; no resp_valid; subsequent request completes normally.
REQ-036 SPI_FLASH_FAST_READ_EN, CLK_DIV=2, addr 0xFFFFFC -> command 0x0B, 8 dummy clocks, resp_valid at cycle 289, correct data.
REQ-037 Protocol checker throughout: mosi stable while sck high; sck low whenever csb high; sck period exactly 2*CLK_DIV.
